e_mdu_ctrl: RTL and testbench

- Multiply/divide unit and its sequencer in the E stage of the 5-stage MIPS pipeline.
- Accepts the 4-bit Op code and E_Start pulse from the E-stage decoder, together with the forwarded rs/rt operands.
- Models a multi-cycle mult/div latency and owns the architectural HI/LO registers.
- Generates the D-stage stall request while an operation is in flight.

---
 rtl/e_mdu_ctrl.sv | 118 +++++++++++
 tb/tb_e_mdu_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu_ctrl.sv
// rtl/e_mdu_ctrl.sv - E-stage multiply/divide unit: owns HI/LO, models mult/div latency, raises D-stage stall
module e_mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  Op,
   input  logic        E_Start,
   input  logic [31:0] E_A,
   input  logic [31:0] E_B,
   input  logic        D_IsMD,
   output logic [31:0] E_HI,
   output logic [31:0] E_LO,
   output logic        Busy,
   output logic        MD_Stall
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [3:0] OP_MULT  = 4'b0000;
   localparam logic [3:0] OP_MULTU = 4'b0001;
   localparam logic [3:0] OP_DIV   = 4'b0010;
   localparam logic [3:0] OP_DIVU  = 4'b0011;
   localparam logic [3:0] OP_MTHI  = 4'b0110;
   localparam logic [3:0] OP_MTLO  = 4'b0111;

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   logic [0:0]  state;
   logic [3:0]  counter;
   logic [31:0] pend_hi;
   logic [31:0] pend_lo;
   logic        pend_wr;

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] div_b;
   logic [31:0] quo_u;
   logic [31:0] rem_u;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] mag_q;
   logic [31:0] mag_r;
   logic [31:0] quo_s;
   logic [31:0] rem_s;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        res_wr;
   logic        is_md;

   // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
   always_comb begin
      prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
      prod_u = {32'd0, E_A} * {32'd0, E_B};
      div_b  = (E_B == 32'd0) ? 32'd1 : E_B;
      quo_u  = E_A / div_b;
      rem_u  = E_A % div_b;
      mag_a  = E_A[31] ? -E_A : E_A;
      mag_b  = E_B[31] ? -E_B : E_B;
      if (mag_b == 32'd0) mag_b = 32'd1;
      mag_q  = mag_a / mag_b;
      mag_r  = mag_a % mag_b;
      quo_s  = (E_A[31] ^ E_B[31]) ? -mag_q : mag_q;
      rem_s  = E_A[31] ? -mag_r : mag_r;

      res_hi = 32'd0;
      res_lo = 32'd0;
      res_wr = 1'b1;
      case (Op)
         OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
         OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
         OP_DIV:   begin res_hi = rem_s; res_lo = quo_s; res_wr = (E_B != 32'd0); end
         OP_DIVU:  begin res_hi = rem_u; res_lo = quo_u; res_wr = (E_B != 32'd0); end
         default:  res_wr = 1'b0;
      endcase
   end

   assign is_md    = (Op[3:2] == 2'b00);
   assign Busy     = E_Start | (state == RUN);
   assign MD_Stall = D_IsMD & Busy;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         counter <= 4'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_wr <= 1'b0;
         E_HI    <= 32'd0;
         E_LO    <= 32'd0;
      end else if (state == IDLE) begin
         if (E_Start && is_md) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= res_wr;
            counter <= Op[1] ? DIV_N : MULT_N;
            state   <= RUN;
         end else if (!Busy) begin
            if (Op == OP_MTHI) E_HI <= E_A;
            if (Op == OP_MTLO) E_LO <= E_A;
         end
      end else begin
         counter <= counter - 4'd1;
         if (counter == 4'd1) begin
            // Divide-by-zero still spends the full busy period but leaves HI/LO alone.
            if (pend_wr) begin
               E_HI <= pend_hi;
               E_LO <= pend_lo;
            end
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// tb/tb_e_mdu_ctrl.sv - scoreboard bench for e_mdu_ctrl with a behavioural HI/LO reference model
module tb_e_mdu_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  Op;
   logic        E_Start;
   logic [31:0] E_A;
   logic [31:0] E_B;
   logic        D_IsMD;
   logic [31:0] E_HI;
   logic [31:0] E_LO;
   logic        Busy;
   logic        MD_Stall;

   e_mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .Op(Op), .E_Start(E_Start), .E_A(E_A), .E_B(E_B),
      .D_IsMD(D_IsMD), .E_HI(E_HI), .E_LO(E_LO), .Busy(Busy), .MD_Stall(MD_Stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic        whi;
      logic        wlo;
      logic [31:0] hi;
      logic [31:0] lo;
   } sb_t;

   sb_t         sbq[$];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   logic        exp_busy = 1'b0;
   logic [31:0] cur_hi = 32'd0;
   logic [31:0] cur_lo = 32'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference arithmetic in 64-bit integers, independent of any RTL structure.
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output logic wr);
      longint p, sa, sb, q, r;
      logic [63:0] pv;
      pv = 64'd0;
      wr = 1'b1;
      case (op)
         4'd0: begin p = longint'($signed(a)) * longint'($signed(b)); pv = p; end
         4'd1: begin p = longint'({32'd0, a}) * longint'({32'd0, b}); pv = p; end
         4'd2: begin
            if (b == 0) wr = 1'b0;
            else begin
               sa = longint'($signed(a)); sb = longint'($signed(b));
               q = sa / sb; r = sa % sb;
               pv = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 0) wr = 1'b0;
            else pv = {a % b, a / b};
         end
      endcase
      hi = pv[63:32];
      lo = pv[31:0];
   endfunction

   always @(posedge clk) cyc = cyc + 1;

   // Monitor: retire scoreboard entries at their due cycle and compare every cycle.
   always @(negedge clk) begin
      sb_t e;
      if (!reset) begin
         sbq.delete();
         cur_hi = 32'd0;
         cur_lo = 32'd0;
      end else begin
         while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            if (e.due != cyc) chk("sb_due", e.due, cyc);
            if (e.whi) cur_hi = e.hi;
            if (e.wlo) cur_lo = e.lo;
         end
      end
      chk("E_HI", E_HI, cur_hi);
      chk("E_LO", E_LO, cur_lo);
      chk("Busy", {31'd0, Busy}, {31'd0, exp_busy});
      chk("MD_Stall", {31'd0, MD_Stall}, {31'd0, D_IsMD & exp_busy});
   end

   task automatic do_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic stall, input logic mid_mthi);
      sb_t e;
      logic [31:0] hi, lo;
      logic wr;
      int n;
      @(posedge clk); #1;
      n = (op < 4'd2) ? MULT_N : DIV_N;
      Op = op; E_Start = 1'b1; E_A = a; E_B = b; D_IsMD = stall; exp_busy = 1'b1;
      model(op, a, b, hi, lo, wr);
      e.due = cyc + 1 + n; e.whi = wr; e.wlo = wr; e.hi = hi; e.lo = lo;
      sbq.push_back(e);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         E_Start = 1'b0;
         E_A = $urandom; E_B = $urandom;
         if (mid_mthi && k == 2) begin Op = 4'b0110; E_A = 32'h0000AAAA; end
         else Op = 4'b1111;
      end
      @(posedge clk); #1;
      exp_busy = 1'b0;
      Op = 4'b1111;
   endtask

   task automatic do_mt(input logic lo_sel, input logic [31:0] a);
      sb_t e;
      @(posedge clk); #1;
      Op = lo_sel ? 4'b0111 : 4'b0110; E_A = a; E_Start = 1'b0; D_IsMD = 1'b0;
      e.due = cyc + 1; e.whi = !lo_sel; e.wlo = lo_sel; e.hi = a; e.lo = a;
      sbq.push_back(e);
      @(posedge clk); #1;
      Op = 4'b1111;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] rop;
      logic [31:0] rb;
      reset = 1'b0; Op = 4'b1111; E_Start = 1'b0; E_A = 32'd0; E_B = 32'd0; D_IsMD = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hi", E_HI, 32'd0);
      chk("rst_lo", E_LO, 32'd0);
      chk("rst_busy", {31'd0, Busy}, 32'd0);
      reset = 1'b1;

      do_md(4'd0, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
      chk("mult_hi", E_HI, 32'hFFFFFFFF);
      chk("mult_lo", E_LO, 32'hFFFFFFFE);
      do_md(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
      chk("multu_hi", E_HI, 32'h00000001);
      chk("multu_lo", E_LO, 32'hFFFFFFFE);
      do_md(4'd2, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b1);
      chk("div_hi", E_HI, 32'hFFFFFFFF);
      chk("div_lo", E_LO, 32'hFFFFFFFD);
      do_mt(1'b0, 32'h00001234);
      do_mt(1'b1, 32'h00005678);
      do_md(4'd3, 32'd7, 32'd0, 1'b1, 1'b0);
      chk("divu0_hi", E_HI, 32'h00001234);
      chk("divu0_lo", E_LO, 32'h00005678);
      do_mt(1'b0, 32'hDEADBEEF);
      do_mt(1'b1, 32'h0BADF00D);
      chk("mthi", E_HI, 32'hDEADBEEF);
      chk("mtlo", E_LO, 32'h0BADF00D);
      do_md(4'd0, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
      chk("mult_min_hi", E_HI, 32'h40000000);
      chk("mult_min_lo", E_LO, 32'h00000000);
      do_md(4'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
      chk("div_ovf_hi", E_HI, 32'h00000000);
      chk("div_ovf_lo", E_LO, 32'h80000000);

      // E_Start with a non-arithmetic Op: busy for that cycle only, no register write.
      @(posedge clk); #1;
      Op = 4'b0110; E_A = 32'h55555555; E_Start = 1'b1; exp_busy = 1'b1;
      @(posedge clk); #1;
      Op = 4'b1111; E_Start = 1'b0; exp_busy = 1'b0;

      for (int i = 0; i < 40; i++) begin
         rop = 4'($urandom_range(0, 7));
         rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         if (rop < 4'd4) do_md(rop, $urandom, rb, 1'($urandom_range(0, 1)), 1'b0);
         else if (rop >= 4'd6) do_mt(rop[0], $urandom);
         else begin
            @(posedge clk); #1;
            Op = rop; D_IsMD = 1'($urandom_range(0, 1));
         end
      end

      // Asynchronous reset two cycles into a mult.
      @(posedge clk); #1;
      Op = 4'd0; E_Start = 1'b1; E_A = 32'h12345678; E_B = 32'h9ABCDEF0; D_IsMD = 1'b0; exp_busy = 1'b1;
      @(posedge clk); #1;
      E_Start = 1'b0; Op = 4'b1111;
      @(posedge clk); #2;
      reset = 1'b0; exp_busy = 1'b0;
      #1;
      chk("arst_hi", E_HI, 32'd0);
      chk("arst_lo", E_LO, 32'd0);
      chk("arst_busy", {31'd0, Busy}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("post_rst_hi", E_HI, 32'd0);
      chk("post_rst_lo", E_LO, 32'd0);
      chk("sb_empty", sbq.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
